// File: rtl/vslc_spi_fetch.sv
// -----------------------------------------------------------------------------
// vslc_spi_fetch
//   Instruction supply for the executor. Streams program bytes out of an SPI
//   serial EEPROM/flash (READ 0x03, ADDR_W-bit address of zero, SPI mode 0) and
//   hands each byte over with a one-clock instr_ready strobe. A scan ends on the
//   end-of-program opcode or when MAX_LEN bytes have been fetched. At that
//   point chip select is released, ui_in is snapshotted into ui_in_prev, and
//   after CS_GAP clocks the read is re-issued from address 0.
//
// Ports
//   clk, rst_n   system clock / asynchronous active-low reset
//   en           run enable, honoured only between scans (IDLE, GAP)
//   spi_miso     serial data from memory
//   spi_sck      SPI clock, idle low
//   spi_mosi     serial command/address to memory
//   spi_cs_n     chip select, active low
//   ui_in        live inputs
//   ui_in_prev   ui_in as captured at the previous scan boundary
//   instr        last delivered instruction byte (held until the next one)
//   instr_ready  one-clock strobe, instr valid
//   scan_done    one-clock strobe at the end of every scan
//   pc           byte index of the next instruction within the scan
// -----------------------------------------------------------------------------
module vslc_spi_fetch #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MAX_LEN    = 1024,
  parameter int unsigned CS_GAP     = 4,
  parameter logic [7:0]  EOP_OPCODE = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              spi_miso,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  input  logic [7:0]        ui_in,
  output logic [7:0]        ui_in_prev,
  output logic [7:0]        instr,
  output logic              instr_ready,
  output logic              scan_done,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_GAP
  } state_t;

  localparam logic [7:0]  READ_CMD = 8'h03;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned BITS_MAX = (ADDR_W > 8) ? ADDR_W : 8;
  localparam int unsigned CNT_W    = $clog2(BITS_MAX);

  state_t             state, state_d;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [7:0]         tx_sr;
  logic [6:0]         rx_sr;

  logic               active, tick, rise, fall, last_bit;
  logic               byte_done, is_eop, at_limit, scan_end, gap_done, start;
  logic [7:0]         rx_byte;

  // Only the command byte is ever non-zero on MOSI; once it has shifted out the
  // register holds zeros, which serve as the address and as the DATA/GAP level.
  assign spi_mosi = tx_sr[7];

  // ---------------------------------------------------------------------------
  // Next-state and per-clock control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d  = state;
    active   = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    tick     = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    rise     = tick && !spi_sck;
    fall     = tick && spi_sck;
    last_bit = (state == S_ADDR) ? (bit_cnt == CNT_W'(ADDR_W - 1))
                                 : (bit_cnt == CNT_W'(7));
    rx_byte  = {rx_sr, spi_miso};
    byte_done = rise && (state == S_DATA) && last_bit;
    is_eop   = (rx_byte == EOP_OPCODE);
    at_limit = (pc == ADDR_W'(MAX_LEN - 1));
    scan_end = byte_done && (is_eop || at_limit);
    gap_done = (state == S_GAP) && (gap_cnt == GAP_W'(CS_GAP - 1));

    unique case (state)
      S_IDLE: if (en)               state_d = S_CMD;
      S_CMD:  if (rise && last_bit) state_d = S_ADDR;
      S_ADDR: if (rise && last_bit) state_d = S_DATA;
      S_DATA: if (scan_end)         state_d = S_GAP;
      S_GAP:  if (gap_done)         state_d = en ? S_CMD : S_IDLE;
      default:                      state_d = S_IDLE;
    endcase

    start = (state_d == S_CMD) && (state != S_CMD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // SPI datapath, pc and strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_cs_n    <= 1'b1;
      spi_sck     <= 1'b0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      instr       <= '0;
      instr_ready <= 1'b0;
      scan_done   <= 1'b0;
      pc          <= '0;
      ui_in_prev  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, regardless of statement order.
      instr_ready <= 1'b0;
      scan_done   <= 1'b0;

      if (start) begin
        // First command bit is on MOSI from cs_n assertion, a full half-period
        // ahead of the first SCK rise.
        spi_cs_n <= 1'b0;
        spi_sck  <= 1'b0;
        tx_sr    <= READ_CMD;
        div_cnt  <= '0;
        bit_cnt  <= '0;
      end else if (active) begin
        div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

        if (fall) tx_sr <= {tx_sr[6:0], 1'b0};

        if (rise) begin
          bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
          if (state == S_DATA) rx_sr <= rx_byte[6:0];
        end

        if (byte_done && !is_eop) begin
          instr       <= rx_byte;
          instr_ready <= 1'b1;
        end

        if (scan_end) begin
          // The 8th bit is sampled here, so the final SCK rise is suppressed
          // and the bus is released on the same clock.
          spi_cs_n   <= 1'b1;
          spi_sck    <= 1'b0;
          scan_done  <= 1'b1;
          ui_in_prev <= ui_in;
          pc         <= '0;
          gap_cnt    <= '0;
        end else begin
          if (tick)      spi_sck <= ~spi_sck;
          if (byte_done) pc      <= pc + ADDR_W'(1);
        end
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vslc_spi_fetch.sv
// -----------------------------------------------------------------------------
// tb_vslc_spi_fetch
//   Directed bench for vslc_spi_fetch with a behavioural SPI mode-0 memory.
//   MAX_LEN is set to 3 so the length limit is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_vslc_spi_fetch;

  localparam int CLK_DIV = 2;
  localparam int ADDR_W  = 16;
  localparam int MAX_LEN = 3;
  localparam int CS_GAP  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              spi_miso = 1'b0;
  logic              spi_sck, spi_mosi, spi_cs_n;
  logic [7:0]        ui_in = 8'h00;
  logic [7:0]        ui_in_prev, instr;
  logic              instr_ready, scan_done;
  logic [ADDR_W-1:0] pc;

  always #5 clk = ~clk;

  vslc_spi_fetch #(
    .CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN),
    .CS_GAP(CS_GAP), .EOP_OPCODE(8'hFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spi_miso(spi_miso),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .ui_in(ui_in), .ui_in_prev(ui_in_prev), .instr(instr),
    .instr_ready(instr_ready), .scan_done(scan_done), .pc(pc)
  );

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // SPI memory model: counts SCK rises per transaction, captures the first 24
  // MOSI bits, and drives program bytes MSB first on SCK falling edges.
  // ---------------------------------------------------------------------------
  logic [7:0]  mem [0:7];
  int          rise_cnt = 0;
  logic [23:0] cmd_sr = '0;
  int          bit_idx;
  logic [2:0]  byte_sel;
  logic [7:0]  cur_byte = '0;

  always @(negedge spi_cs_n or posedge spi_sck) begin
    if (!spi_sck) begin
      rise_cnt = 0;
      cmd_sr   = '0;
    end else if (!spi_cs_n) begin
      if (rise_cnt < 24) cmd_sr = {cmd_sr[22:0], spi_mosi};
      rise_cnt++;
    end
  end

  always @(negedge spi_sck) begin
    if (!spi_cs_n && rise_cnt >= 24) begin
      bit_idx = rise_cnt - 24;
      if (bit_idx % 8 == 0) begin
        byte_sel = 3'(bit_idx / 8);
        cur_byte = mem[byte_sel];
      end
      spi_miso = cur_byte[7];
      cur_byte = {cur_byte[6:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // Event log sampled on the falling clock edge
  // ---------------------------------------------------------------------------
  int          n_ready = 0;
  logic [7:0]  rdy_instr[$];
  logic [15:0] rdy_pc[$];
  logic [7:0]  rdy_prev[$];
  bit          rdy_with_done[$];
  int          done_ready_at[$];
  int          done_rise[$];
  logic [23:0] done_cmd[$];
  logic [7:0]  done_prev[$];
  logic [7:0]  done_instr[$];
  logic [15:0] done_pc[$];

  always @(negedge clk) begin
    if (instr_ready) begin
      rdy_instr.push_back(instr);
      rdy_pc.push_back(pc);
      rdy_prev.push_back(ui_in_prev);
      rdy_with_done.push_back(scan_done);
      n_ready++;
    end
    if (scan_done) begin
      done_ready_at.push_back(n_ready);
      done_rise.push_back(rise_cnt);
      done_cmd.push_back(cmd_sr);
      done_prev.push_back(ui_in_prev);
      done_instr.push_back(instr);
      done_pc.push_back(pc);
    end
  end

  // Waits for k scan_done pulses; returns on the falling edge that saw the last.
  task automatic wait_done(input int k, input int budget, output bit ok);
    int seen = 0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (scan_done) seen++;
      if (seen >= k) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int lows = 0;
    repeat (3) @(negedge clk);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b, expected 1", spi_cs_n); end
    checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b, expected 0", spi_sck); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b, expected 0", spi_mosi); end
    checks++; if ({instr, instr_ready, scan_done, pc, ui_in_prev} !== '0) begin errors++;
      $display("FAIL reset_outputs: got instr=%h rdy=%b done=%b pc=%h prev=%h, expected all 0", instr, instr_ready, scan_done, pc, ui_in_prev); end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (!spi_cs_n) lows++; end
    checks++; if (lows !== 0) begin errors++; $display("FAIL idle_no_en: got %0d cs_n-low clocks, expected 0", lows); end
  endtask

  task automatic test_fetch_and_ui_prev();
    bit ok;
    int highs;
    mem[0] = 8'h01; mem[1] = 8'h9C; mem[2] = 8'hFF;
    ui_in = 8'h5A;
    en = 1'b1;
    wait_done(1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan1_timeout: got no scan_done, expected one"); return; end
    checks++; if (done_cmd[0] !== 24'h030000) begin errors++; $display("FAIL scan1_cmd: got %h, expected 030000", done_cmd[0]); end
    checks++; if (done_rise[0] !== 47) begin errors++; $display("FAIL scan1_sck_rises: got %0d, expected 47", done_rise[0]); end
    checks++; if (done_ready_at[0] !== 2) begin errors++; $display("FAIL scan1_ready_count: got %0d, expected 2", done_ready_at[0]); end
    checks++; if ({rdy_instr[0], rdy_instr[1]} !== 16'h019C) begin errors++; $display("FAIL scan1_instr: got %h %h, expected 01 9C", rdy_instr[0], rdy_instr[1]); end
    checks++; if ({rdy_pc[0], rdy_pc[1]} !== {16'd1, 16'd2}) begin errors++; $display("FAIL scan1_pc: got %0d %0d, expected 1 2", rdy_pc[0], rdy_pc[1]); end
    checks++; if ({rdy_prev[0], rdy_prev[1]} !== 16'h0000) begin errors++; $display("FAIL scan1_prev_stable: got %h %h, expected 00 00", rdy_prev[0], rdy_prev[1]); end
    checks++; if (done_prev[0] !== 8'h5A) begin errors++; $display("FAIL scan1_ui_prev: got %h, expected 5A", done_prev[0]); end
    checks++; if (done_instr[0] !== 8'h9C) begin errors++; $display("FAIL scan1_eop_hidden: got instr %h, expected 9C", done_instr[0]); end
    checks++; if (done_pc[0] !== 16'd0) begin errors++; $display("FAIL scan1_pc_clear: got %0d, expected 0", done_pc[0]); end
    ui_in = 8'hA5;
    highs = 1;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (spi_cs_n) highs++; else break; end
    checks++; if (highs !== CS_GAP) begin errors++; $display("FAIL gap_len: got %0d clocks, expected %0d", highs, CS_GAP); end
    wait_done(1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan2_timeout: got no scan_done, expected one"); return; end
    checks++; if (done_cmd[1] !== 24'h030000) begin errors++; $display("FAIL scan2_cmd: got %h, expected 030000", done_cmd[1]); end
    checks++; if (done_ready_at[1] !== 4) begin errors++; $display("FAIL scan2_ready_count: got %0d, expected 4", done_ready_at[1]); end
    checks++; if ({rdy_instr[2], rdy_instr[3]} !== 16'h019C) begin errors++; $display("FAIL scan2_instr: got %h %h, expected 01 9C", rdy_instr[2], rdy_instr[3]); end
    checks++; if ({rdy_prev[2], rdy_prev[3]} !== 16'h5A5A) begin errors++; $display("FAIL scan2_prev_stable: got %h %h, expected 5A 5A", rdy_prev[2], rdy_prev[3]); end
    checks++; if (done_prev[1] !== 8'hA5) begin errors++; $display("FAIL scan2_ui_prev: got %h, expected A5", done_prev[1]); end
  endtask

  task automatic test_en_mid_scan();
    bit ok;
    int lows = 0;
    int got_low = 0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (!spi_cs_n) begin got_low = 1; break; end end
    checks++; if (got_low !== 1) begin errors++; $display("FAIL scan3_start: got no cs_n assertion, expected one"); return; end
    en = 1'b0;
    wait_done(1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan3_completes: got no scan_done, expected one"); return; end
    checks++; if (done_ready_at[2] - done_ready_at[1] !== 2) begin errors++;
      $display("FAIL scan3_ready_count: got %0d, expected 2", done_ready_at[2] - done_ready_at[1]); end
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (!spi_cs_n) lows++; end
    checks++; if (lows !== 0) begin errors++; $display("FAIL stop_after_en_low: got %0d cs_n-low clocks, expected 0", lows); end
  endtask

  task automatic test_max_len();
    bit ok;
    int base;
    int last;
    for (int i = 0; i < 8; i++) mem[i] = 8'h10;
    base = n_ready;
    en = 1'b1;
    wait_done(2, 4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL maxlen_timeout: got fewer than 2 scans, expected 2"); return; end
    for (int s = 3; s <= 4; s++) begin
      last = done_ready_at[s] - 1;
      checks++; if (done_ready_at[s] - done_ready_at[s-1] !== MAX_LEN) begin errors++;
        $display("FAIL maxlen_count: got %0d in scan %0d, expected %0d", done_ready_at[s] - done_ready_at[s-1], s, MAX_LEN); end
      checks++; if ({rdy_with_done[last], rdy_with_done[last-1]} !== 2'b10) begin errors++;
        $display("FAIL maxlen_coincident: got last=%b prior=%b, expected 1 0", rdy_with_done[last], rdy_with_done[last-1]); end
      checks++; if ({rdy_pc[last-2], rdy_pc[last-1], rdy_pc[last]} !== {16'd1, 16'd2, 16'd0}) begin errors++;
        $display("FAIL maxlen_pc: got %0d %0d %0d, expected 1 2 0", rdy_pc[last-2], rdy_pc[last-1], rdy_pc[last]); end
    end
    for (int i = base; i < n_ready; i++) begin
      checks++; if (rdy_instr[i] !== 8'h10) begin errors++; $display("FAIL maxlen_instr: got %h at strobe %0d, expected 10", rdy_instr[i], i); end
    end
    en = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_empty_program();
    bit ok;
    int base = n_ready;
    mem[0] = 8'hFF;
    en = 1'b1;
    wait_done(3, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL empty_timeout: got fewer than 3 scans, expected 3"); return; end
    checks++; if (n_ready !== base) begin errors++; $display("FAIL empty_no_ready: got %0d strobes, expected 0", n_ready - base); end
    checks++; if (done_rise[done_rise.size()-1] !== 31) begin errors++;
      $display("FAIL empty_sck_rises: got %0d, expected 31", done_rise[done_rise.size()-1]); end
    checks++; if (instr !== 8'h10) begin errors++; $display("FAIL empty_instr_hold: got %h, expected 10", instr); end
  endtask

  task automatic test_reset_mid_addr();
    bit ok;
    int found = 0;
    int base;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!spi_cs_n && rise_cnt == 14) begin found = 1; break; end
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL addr_bit5_reach: got no ADDR bit 5, expected one"); return; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({spi_cs_n, spi_sck, spi_mosi} !== 3'b100) begin errors++;
      $display("FAIL async_reset_spi: got cs_n=%b sck=%b mosi=%b, expected 1 0 0", spi_cs_n, spi_sck, spi_mosi); end
    checks++; if ({instr, instr_ready, scan_done, pc, ui_in_prev} !== '0) begin errors++;
      $display("FAIL async_reset_outputs: got instr=%h pc=%h prev=%h, expected 0 0 0", instr, pc, ui_in_prev); end
    @(negedge clk);
    rst_n = 1'b1;
    base = n_ready;
    wait_done(1, 2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_reset_timeout: got no scan_done, expected one"); return; end
    checks++; if (done_cmd[done_cmd.size()-1] !== 24'h030000) begin errors++;
      $display("FAIL post_reset_cmd: got %h, expected 030000", done_cmd[done_cmd.size()-1]); end
    checks++; if (n_ready !== base) begin errors++; $display("FAIL post_reset_ready: got %0d strobes, expected 0", n_ready - base); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_fetch_and_ui_prev();
    test_en_mid_scan();
    test_max_len();
    test_empty_program();
    test_reset_mid_addr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
